sr_ff_driver: RTL and testbench
===============================

SR_FF_DRIVER -- requirements
Module: sr_ff_driver

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the number of target bits in one pattern (legal range 2-16).
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL provide port start, input, 1 bit, a request to drive a new pattern.
REQ-005 SHALL provide port pattern, input, WIDTH bits, the target q sequence, driven LSB first.
REQ-006 SHALL provide port sr, output, 2 bits, the {S,R} command to the SR flip-flop (bit1=S, bit0=R); it is registered.
REQ-007 SHALL provide port q_fb, input, 1 bit, the flip-flop q fed back for checking.
REQ-008 SHALL provide port busy, output, 1 bit, high while a pattern is in progress.
REQ-009 SHALL provide port done, output, 1 bit, a one-cycle pulse when a pattern completes.
REQ-010 SHALL provide port err_cnt, output, 4 bits, the count of mismatches in the current or last pattern.

Function
REQ-011 SHALL implement a state machine with states IDLE, DRIVE, CHECK and FIN.
REQ-012 In IDLE, start=1 SHALL latch pattern, clear err_cnt, set idx=0, and move to DRIVE; start SHALL be ignored in all other states.
REQ-013 On every transition into DRIVE, sr SHALL load the excitation code for target t=pattern[idx] versus the model bit m:
  - m=0,t=0 -> 00
  - m=0,t=1 -> 10
  - m=1,t=0 -> 01
  - m=1,t=1 -> 00
REQ-014 sr SHALL never equal 11 in any state, including the cycles immediately after reset.
REQ-015 The DRIVE->CHECK transition is unconditional after one cycle; on it, sr<=00 and m<=pattern[idx].
REQ-016 In CHECK, at the next edge the block SHALL compare q_fb with m.
  - Mismatch: err_cnt SHALL increment, saturating at 15.
  - idx<WIDTH-1: idx SHALL increment and the block SHALL return to DRIVE.
  - idx=WIDTH-1: the block SHALL go to FIN.
REQ-017 FIN SHALL last exactly one cycle, during which done=1; the block then SHALL return to IDLE with sr=00.
REQ-018 busy SHALL be 1 in DRIVE, CHECK and FIN, and 0 in IDLE.
REQ-019 Latency SHALL be fixed: start accepted at edge E gives done=1 in the cycle after edge E+2*WIDTH, and busy falls at edge E+2*WIDTH+1.
REQ-020 The model bit m SHALL persist across patterns; only reset SHALL clear it.
REQ-021 err_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-022 start asserted in the same cycle as FIN SHALL be ignored; start SHALL be re-sampled in IDLE.

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, sr=00, busy=0, done=0, err_cnt=0, idx=0 and m=0, matching the flip-flop's power-up q=0.
REQ-024 rst asserted mid-pattern SHALL abort the pattern immediately, with no done pulse.
REQ-025 After rst deasserts, the first rising edge SHALL accept start.

Verification
REQ-026 The bench SHALL drive pattern=8'b1010_0110 with a correct SR_FF on q_fb.
  - Required sr sequence per DRIVE: 00, 10, 00, 01, 00, 10, 01, 10.
  - Required: err_cnt=0, done one cycle after edge E+16.
REQ-027 The bench SHALL drive pattern=8'hFF then 8'hFF.
  - First pattern: sr=10 once, then 00.
  - Second pattern: all DRIVE codes 00, since m persists as 1.
REQ-028 The bench SHALL force q_fb=0 and drive pattern=8'hFF twice back-to-back.
  - Required: err_cnt=8 after the first pattern.
  - Required: err_cnt=8 after the second pattern, since it is cleared on start.
  - With WIDTH=16, pattern=16'hFFFF: err_cnt SHALL saturate at 15.
REQ-029 The bench SHALL pulse start repeatedly while busy.
  - Required: no restart and an unchanged latency.
  - Required: start held high through FIN is accepted only at the following IDLE cycle.
REQ-030 The bench SHALL assert rst in CHECK at idx=3.
  - Required in the same cycle: sr=00, busy=0, err_cnt=0.
  - Required: no done pulse.
  - Required: a following pattern 8'h01 drives sr=10 first, since m=0.

Source files
------------

// File: rtl/sr_ff_driver.sv
// Sequencer that walks an external SR flip-flop through a target bit pattern,
// one bit per DRIVE/CHECK pair, and counts cycles where the fed-back q
// disagrees with the internal model of what q should be.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; err_cnt holds last result
// DRIVE | sr carries the excitation code for pattern[idx]
// CHECK | sr back to 00; q_fb compared with model bit at next edge
// FIN   | one-cycle done pulse, then back to IDLE
module sr_ff_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic [1:0]       sr,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic [3:0]       err_cnt
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sr_q, sr_d;
    logic             m_q, m_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       err_q, err_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]    idx_nxt;

    // {S,R} needed to move q from m to t; S and R are never both set.
    function automatic logic [1:0] excite(input logic m, input logic t);
        return {t & ~m, m & ~t};
    endfunction

    assign idx_nxt = idx_q + IW'(1);

    // State, command and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= 2'b00;
            m_q     <= 1'b0;
            idx_q   <= '0;
            err_q   <= 4'd0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            pat_q   <= pat_d;
        end
    end

    // Next-state logic; sr defaults to 00 so only DRIVE entry can excite.
    always_comb begin
        state_d = state_q;
        sr_d    = 2'b00;
        m_d     = m_q;
        idx_d   = idx_q;
        err_d   = err_q;
        pat_d   = pat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    err_d   = 4'd0;
                    idx_d   = '0;
                    sr_d    = excite(m_q, pattern[0]);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                m_d     = pat_q[idx_q];
                state_d = CHECK;
            end
            CHECK: begin
                if ((q_fb != m_q) && (err_q != 4'hF)) begin
                    err_d = err_q + 4'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_nxt;
                    sr_d    = excite(m_q, pat_q[idx_nxt]);
                    state_d = DRIVE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sr      = sr_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign err_cnt = err_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver: an 8-bit instance driving a behavioural SR
// flip-flop, plus a 16-bit instance with q tied low for saturation.
module tb_sr_ff_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  pattern8 = '0;
    logic [1:0]  sr8;
    logic        q_fb8;
    logic        busy8, done8;
    logic [3:0]  err8;

    logic        start16 = 1'b0;
    logic [15:0] pattern16 = '0;
    logic [1:0]  sr16;
    logic        busy16, done16;
    logic [3:0]  err16;

    logic        ff_q;
    logic        qforce = 1'b0;
    logic        m_mdl = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] sr_exp_q[$];
    logic [3:0] err_exp_q[$];

    sr_ff_driver #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .pattern(pattern8),
        .sr(sr8), .q_fb(q_fb8), .busy(busy8), .done(done8), .err_cnt(err8)
    );

    sr_ff_driver #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .pattern(pattern16),
        .sr(sr16), .q_fb(1'b0), .busy(busy16), .done(done16), .err_cnt(err16)
    );

    always #5 clk = ~clk;

    // Behavioural SR flip-flop, powers up / resets to q=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= 1'b0;
        else begin
            case (sr8)
                2'b10:   ff_q <= 1'b1;
                2'b01:   ff_q <= 1'b0;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_fb8 = qforce ? 1'b0 : ff_q;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // The forbidden command must never appear on either instance.
    always @(negedge clk) begin
        check("sr8_not_11", {31'd0, sr8 == 2'b11}, 32'd0);
        check("sr16_not_11", {31'd0, sr16 == 2'b11}, 32'd0);
    end

    // Runs one 8-bit pattern from a negedge in IDLE; ends at the negedge of
    // the first IDLE cycle after FIN.
    task automatic run8(input logic [7:0] pat, input bit hold, input bit pulse);
        logic [3:0] e;
        logic t;
        e = 4'd0;
        for (int i = 0; i < 8; i++) begin
            t = pat[i];
            sr_exp_q.push_back({t & ~m_mdl, m_mdl & ~t});
            if (qforce && t) e = (e == 4'hF) ? 4'hF : e + 4'd1;
            m_mdl = t;
        end
        err_exp_q.push_back(e);

        pattern8 = pat;
        start8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("sr_drive", sr8, sr_exp_q.pop_front());
            check("busy_drive", busy8, 1);
            check("done_drive", done8, 0);
            if (pulse) start8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("sr_check", sr8, 0);
            check("busy_check", busy8, 1);
            check("done_check", done8, 0);
            if (pulse) start8 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("done_fin", done8, 1);
        check("busy_fin", busy8, 1);
        check("sr_fin", sr8, 0);
        check("err_fin", err8, err_exp_q.pop_front());
        start8 = hold;
        @(negedge clk);
        check("busy_idle", busy8, 0);
        check("done_idle", done8, 0);
        check("sr_idle", sr8, 0);
        check("err_hold", err8, e);
    endtask

    initial begin
        int cnt;
        #1;
        check("rst_sr", sr8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_err", err8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Mixed pattern with a correct flip-flop: 00,10,00,01,00,10,01,10.
        run8(8'b1010_0110, 0, 0);
        // Bring the model back to 0, then two all-ones patterns.
        run8(8'h00, 0, 0);
        run8(8'hFF, 0, 0);
        run8(8'hFF, 0, 0);
        // q stuck low: 8 mismatches each, cleared on each start.
        qforce = 1'b1;
        run8(8'hFF, 0, 0);
        run8(8'hFF, 0, 0);
        qforce = 1'b0;
        // Start toggled while busy, then start held through FIN.
        run8(8'b1010_0110, 0, 1);
        run8(8'h3C, 1, 0);
        run8(8'hC3, 0, 0);

        // Abort in CHECK at idx=3 with q stuck low.
        qforce   = 1'b1;
        pattern8 = 8'hFF;
        start8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_pre_busy", busy8, 1);
        check("abort_pre_err", err8, 3);
        rst = 1'b1;
        #1;
        check("abort_sr", sr8, 0);
        check("abort_busy", busy8, 0);
        check("abort_err", err8, 0);
        check("abort_done", done8, 0);
        m_mdl = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        qforce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_done", done8, 0);
        end
        run8(8'h01, 0, 0);

        // 16-bit instance, q tied low: 16 mismatches saturate at 15.
        pattern16 = 16'hFFFF;
        start16   = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (done16) break;
            @(posedge clk);
            cnt++;
        end
        check("lat16", cnt, 32);
        check("err16_sat", err16, 15);
        @(negedge clk);
        check("busy16_idle", busy16, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
